// File: rtl/dual_port_bank_arbiter.sv
// Two-port to NUM_BANK-bank arbiter: parallel grants for different banks,
// same-bank conflicts serialized by round-robin or fixed A priority.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   a_* / b_*         request ports (req/we/addr/wdata in, ready/rvalid/rdata out)
//   bank_en, bank_we  registered per-bank strobes
//   bank_addr         per-bank in-bank offset, bank i at slice i
//   bank_wdata        per-bank write data, bank i at slice i
//   bank_rdata        per-bank read data, valid the cycle after bank_en
//   conflict_cnt      saturating count of same-bank conflict cycles
//
// Build option: define BANK_ARB_RR_EN for round-robin conflict resolution;
// left undefined, port A always wins a same-bank conflict.

module dual_port_bank_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int NUM_BANK  = 4,
   parameter int BANK_BITS = 2,
   parameter int CNT_W     = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    a_req,
   input  logic                                    a_we,
   input  logic [ADDR_W-1:0]                       a_addr,
   input  logic [DATA_W-1:0]                       a_wdata,
   output logic                                    a_ready,
   output logic                                    a_rvalid,
   output logic [DATA_W-1:0]                       a_rdata,
   input  logic                                    b_req,
   input  logic                                    b_we,
   input  logic [ADDR_W-1:0]                       b_addr,
   input  logic [DATA_W-1:0]                       b_wdata,
   output logic                                    b_ready,
   output logic                                    b_rvalid,
   output logic [DATA_W-1:0]                       b_rdata,
   output logic [NUM_BANK-1:0]                     bank_en,
   output logic [NUM_BANK-1:0]                     bank_we,
   output logic [NUM_BANK*(ADDR_W-BANK_BITS)-1:0]  bank_addr,
   output logic [NUM_BANK*DATA_W-1:0]              bank_wdata,
   input  logic [NUM_BANK*DATA_W-1:0]              bank_rdata,
   output logic [CNT_W-1:0]                        conflict_cnt
);

   localparam int OFF_W = ADDR_W - BANK_BITS;

   logic [BANK_BITS-1:0] bank_a;
   logic [BANK_BITS-1:0] bank_b;
   logic [NUM_BANK-1:0]  sel_a;
   logic [NUM_BANK-1:0]  sel_b;
   logic                 conflict;
   logic                 a_win;
   logic                 a_go;
   logic                 b_go;

   assign bank_a   = a_addr[ADDR_W-1 -: BANK_BITS];
   assign bank_b   = b_addr[ADDR_W-1 -: BANK_BITS];
   assign sel_a    = NUM_BANK'(1) << bank_a;
   assign sel_b    = NUM_BANK'(1) << bank_b;
   assign conflict = a_req & b_req & (bank_a == bank_b);

`ifdef BANK_ARB_RR_EN
   // rr_ptr = 1 means B is preferred on the next conflict
   logic rr_ptr;

   assign a_win = ~rr_ptr;

   // After a conflict the pointer moves to the port that just lost
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (conflict) begin
         rr_ptr <= a_win;
      end
   end
`else
   assign a_win = 1'b1;
`endif

   // Nothing is accepted during reset, since it would be discarded anyway
   assign a_go    = ~rst & a_req & (~conflict | a_win);
   assign b_go    = ~rst & b_req & (~conflict | ~a_win);
   assign a_ready = a_go;
   assign b_ready = b_go;

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (conflict && !(&conflict_cnt)) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

   // Grant guarantees at most one port hits a given bank per cycle.
   // Idle banks keep their last offset and write data.
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_en    <= '0;
         bank_we    <= '0;
         bank_addr  <= '0;
         bank_wdata <= '0;
      end else begin
         for (int i = 0; i < NUM_BANK; i++) begin
            if (a_go && sel_a[i]) begin
               bank_en[i]                     <= 1'b1;
               bank_we[i]                     <= a_we;
               bank_addr[i*OFF_W +: OFF_W]    <= a_addr[OFF_W-1:0];
               bank_wdata[i*DATA_W +: DATA_W] <= a_wdata;
            end else if (b_go && sel_b[i]) begin
               bank_en[i]                     <= 1'b1;
               bank_we[i]                     <= b_we;
               bank_addr[i*OFF_W +: OFF_W]    <= b_addr[OFF_W-1:0];
               bank_wdata[i*DATA_W +: DATA_W] <= b_wdata;
            end else begin
               bank_en[i] <= 1'b0;
               bank_we[i] <= 1'b0;
            end
         end
      end
   end

   // Read return: read flag and bank index travel two stages so rvalid
   // lines up with the cycle the bank macro presents its registered data.
   logic                 a_rd1;
   logic                 b_rd1;
   logic [BANK_BITS-1:0] a_bk1;
   logic [BANK_BITS-1:0] a_bk2;
   logic [BANK_BITS-1:0] b_bk1;
   logic [BANK_BITS-1:0] b_bk2;
   logic [DATA_W-1:0]    a_hold;
   logic [DATA_W-1:0]    b_hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_rd1    <= 1'b0;
         b_rd1    <= 1'b0;
         a_bk1    <= '0;
         a_bk2    <= '0;
         b_bk1    <= '0;
         b_bk2    <= '0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_hold   <= '0;
         b_hold   <= '0;
      end else begin
         a_rd1    <= a_go & ~a_we;
         b_rd1    <= b_go & ~b_we;
         a_bk1    <= bank_a;
         b_bk1    <= bank_b;
         a_rvalid <= a_rd1;
         b_rvalid <= b_rd1;
         a_bk2    <= a_bk1;
         b_bk2    <= b_bk1;
         if (a_rvalid) begin
            a_hold <= a_rdata;
         end
         if (b_rvalid) begin
            b_hold <= b_rdata;
         end
      end
   end

   // The bank macro output is already a register; the hold register keeps
   // the last returned word stable while rvalid is low.
   assign a_rdata = a_rvalid ? bank_rdata[int'(a_bk2)*DATA_W +: DATA_W]
                             : a_hold;
   assign b_rdata = b_rvalid ? bank_rdata[int'(b_bk2)*DATA_W +: DATA_W]
                             : b_hold;

endmodule

// File: tb/tb_dual_port_bank_arbiter.sv
// Directed bench for dual_port_bank_arbiter with a synchronous-read
// bank memory model; vector table plus hand-written multi-cycle sequences.

module tb_dual_port_bank_arbiter;

   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [7:0]  a_addr, a_wdata, b_addr, b_wdata;
   logic        a_ready, a_rvalid, b_ready, b_rvalid;
   logic [7:0]  a_rdata, b_rdata;
   logic [3:0]  bank_en, bank_we;
   logic [23:0] bank_addr;
   logic [31:0] bank_wdata;
   logic [31:0] bank_rdata;
   logic [3:0]  conflict_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dual_port_bank_arbiter #(
      .ADDR_W(8), .DATA_W(8), .NUM_BANK(4), .BANK_BITS(2), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
      .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
      .conflict_cnt(conflict_cnt)
   );

   // Bank macros: registered read, contents preset to their own address
   logic [7:0] mem [4][64];

   always @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 4; b++)
            for (int o = 0; o < 64; o++)
               mem[b][o] <= 8'(b*64 + o);
         bank_rdata <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (bank_en[b]) begin
               if (bank_we[b])
                  mem[b][bank_addr[b*6 +: 6]] <= bank_wdata[b*8 +: 8];
               else
                  bank_rdata[b*8 +: 8] <= mem[b][bank_addr[b*6 +: 6]];
            end
         end
      end
   end

   typedef struct {
      logic ar; logic aw; logic [7:0] aa; logic [7:0] ad;
      logic br; logic bw; logic [7:0] ba; logic [7:0] bd;
      logic ardy; logic brdy;
      logic [3:0] en; logic [3:0] we;
      logic [23:0] addr; logic [31:0] wd;
      logic arv; logic [7:0] ard; logic brv; logic [7:0] brd;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      idle_in();
      tick();
      tick();
      rst = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".en"},   32'(bank_en), 0);
      chk({tag, ".we"},   32'(bank_we), 0);
      chk({tag, ".addr"}, 32'(bank_addr), 0);
      chk({tag, ".wd"},   bank_wdata, 0);
      chk({tag, ".arv"},  32'(a_rvalid), 0);
      chk({tag, ".brv"},  32'(b_rvalid), 0);
      chk({tag, ".ard"},  32'(a_rdata), 0);
      chk({tag, ".brd"},  32'(b_rdata), 0);
      chk({tag, ".cnt"},  32'(conflict_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: timeout");
      $fatal(1);
   end

   initial begin
      // Parallel writes/reads, back-to-back reads, read-after-write
      tbl[0] = '{T,T,8'h05,8'hAA, T,T,8'h45,8'h55, T,T,
                 4'h0,4'h0,24'h000000,32'h00000000, F,8'h00,F,8'h00};
      tbl[1] = '{T,F,8'h05,8'h00, T,F,8'h45,8'h00, T,T,
                 4'h3,4'h3,24'h000145,32'h000055AA, F,8'h00,F,8'h00};
      tbl[2] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,
                 4'h3,4'h0,24'h000145,32'h00000000, F,8'h00,F,8'h00};
      tbl[3] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,
                 4'h0,4'h0,24'h000145,32'h00000000, T,8'hAA,T,8'h55};
      tbl[4] = '{T,T,8'hC3,8'h3C, T,F,8'h05,8'h00, T,T,
                 4'h0,4'h0,24'h000145,32'h00000000, F,8'hAA,F,8'h55};
      tbl[5] = '{T,F,8'h45,8'h00, T,F,8'hC3,8'h00, T,T,
                 4'h9,4'h8,24'h0C0145,32'h3C000000, F,8'hAA,F,8'h55};
      tbl[6] = '{T,F,8'h05,8'h00, F,F,8'h00,8'h00, T,F,
                 4'hA,4'h0,24'h0C0145,32'h00000000, F,8'hAA,T,8'hAA};
      tbl[7] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,
                 4'h1,4'h0,24'h0C0145,32'h00000000, T,8'h55,T,8'h3C};
      tbl[8] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,
                 4'h0,4'h0,24'h0C0145,32'h00000000, T,8'hAA,F,8'h3C};
      tbl[9] = '{F,F,8'h00,8'h00, F,F,8'h00,8'h00, F,F,
                 4'h0,4'h0,24'h0C0145,32'h00000000, F,8'hAA,F,8'h3C};

      // Reset, then idle
      do_reset();
      chk_zero("rst");
      chk("rst.ardy", 32'(a_ready), 0);
      chk("rst.brdy", 32'(b_ready), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("idle%0d.en", i),  32'(bank_en), 0);
         chk($sformatf("idle%0d.arv", i), 32'(a_rvalid), 0);
         chk($sformatf("idle%0d.brv", i), 32'(b_rvalid), 0);
         chk($sformatf("idle%0d.cnt", i), 32'(conflict_cnt), 0);
      end

      // Vector table, one cycle per row
      for (int i = 0; i < 10; i++) begin
         a_req = tbl[i].ar; a_we = tbl[i].aw;
         a_addr = tbl[i].aa; a_wdata = tbl[i].ad;
         b_req = tbl[i].br; b_we = tbl[i].bw;
         b_addr = tbl[i].ba; b_wdata = tbl[i].bd;
         #1;
         chk($sformatf("v%0d.ardy", i), 32'(a_ready), 32'(tbl[i].ardy));
         chk($sformatf("v%0d.brdy", i), 32'(b_ready), 32'(tbl[i].brdy));
         chk($sformatf("v%0d.en", i),   32'(bank_en), 32'(tbl[i].en));
         chk($sformatf("v%0d.we", i),   32'(bank_we), 32'(tbl[i].we));
         chk($sformatf("v%0d.addr", i), 32'(bank_addr), 32'(tbl[i].addr));
         chk($sformatf("v%0d.wd", i),   bank_wdata, tbl[i].wd);
         chk($sformatf("v%0d.arv", i),  32'(a_rvalid), 32'(tbl[i].arv));
         chk($sformatf("v%0d.ard", i),  32'(a_rdata), 32'(tbl[i].ard));
         chk($sformatf("v%0d.brv", i),  32'(b_rvalid), 32'(tbl[i].brv));
         chk($sformatf("v%0d.brd", i),  32'(b_rdata), 32'(tbl[i].brd));
         chk($sformatf("v%0d.cnt", i),  32'(conflict_cnt), 0);
         tick();
      end

      // Same-bank conflict: A reads 0x81, B reads 0x82
      a_req = 1; a_we = 0; a_addr = 8'h81;
      b_req = 1; b_we = 0; b_addr = 8'h82;
`ifdef BANK_ARB_RR_EN
      #1;
      chk("rr0.ardy", 32'(a_ready), 1);
      chk("rr0.brdy", 32'(b_ready), 0);
      tick();
      chk("rr1.ardy", 32'(a_ready), 0);
      chk("rr1.brdy", 32'(b_ready), 1);
      chk("rr1.cnt",  32'(conflict_cnt), 1);
      chk("rr1.en",   32'(bank_en), 4'h4);
      tick();
      idle_in();
      #1;
      chk("rr2.cnt",  32'(conflict_cnt), 2);
      chk("rr2.arv",  32'(a_rvalid), 1);
      chk("rr2.ard",  32'(a_rdata), 8'h81);
      chk("rr2.brv",  32'(b_rvalid), 0);
      tick();
      chk("rr3.brv",  32'(b_rvalid), 1);
      chk("rr3.brd",  32'(b_rdata), 8'h82);
      chk("rr3.arv",  32'(a_rvalid), 0);
      tick();
`else
      for (int j = 0; j < 3; j++) begin
         #1;
         chk($sformatf("fp%0d.ardy", j), 32'(a_ready), 1);
         chk($sformatf("fp%0d.brdy", j), 32'(b_ready), 0);
         chk($sformatf("fp%0d.cnt", j),  32'(conflict_cnt), 32'(j));
         tick();
      end
      a_req = 0;
      #1;
      chk("fp3.brdy", 32'(b_ready), 1);
      chk("fp3.cnt",  32'(conflict_cnt), 3);
      chk("fp3.arv",  32'(a_rvalid), 1);
      chk("fp3.ard",  32'(a_rdata), 8'h81);
      tick();
      b_req = 0;
      #1;
      chk("fp4.arv",  32'(a_rvalid), 1);
      chk("fp4.cnt",  32'(conflict_cnt), 3);
      tick();
      chk("fp5.brv",  32'(b_rvalid), 1);
      chk("fp5.brd",  32'(b_rdata), 8'h82);
      chk("fp5.arv",  32'(a_rvalid), 0);
      tick();
`endif

      // Counter saturation at 4'hF
      do_reset();
      a_req = 1; a_addr = 8'h81;
      b_req = 1; b_addr = 8'h82;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk($sformatf("sat%0d.cnt", i), 32'(conflict_cnt),
             (i < 15) ? 32'(i) : 32'hF);
      end
      idle_in();
      tick();
      tick();
      tick();

      // Reset while a read is in flight
      a_req = 1; a_we = 0; a_addr = 8'h05;
      #1;
      chk("mid.ardy", 32'(a_ready), 1);
      tick();
      a_req = 0;
      rst = 1;
      #1;
      chk("mid.en1", 32'(bank_en), 4'h1);
      tick();
      rst = 0;
      chk_zero("mid2");
      tick();
      chk("mid3.arv", 32'(a_rvalid), 0);
      chk("mid3.en",  32'(bank_en), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
